// File: rtl/mc_ctrl.sv
// Multicycle main controller for the MIPS datapath.
// Optional trap on illegal instructions: define MC_CTRL_TRAP_EN.
module mc_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_3180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcwr,
  output logic       irwr,
  output logic       gprwr,
  output logic       dmwr,
  output logic [1:0] gprsel,
  output logic       isjalr,
  output logic [1:0] wdsel,
  output logic [2:0] npcop,
  output logic [1:0] aluop,
  output logic       extop,
  output logic       bsel,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_EXE   = 4'd2,
    S_WB    = 4'd3,
    S_MA    = 4'd4,
    S_MR    = 4'd5,
    S_MW    = 4'd6,
    S_MWB   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9,
    S_TRAP  = 4'd10
  } state_t;

  state_t state, state_nx;
  logic   run;

  // TRAP_VEC is consumed by the npc mux; referenced here only to keep it bound.
  logic unused_trap;
  assign unused_trap = ^TRAP_VEC;

  logic rtype;
  logic i_addu, i_subu, i_jr, i_jalr;
  logic i_ori, i_lui, i_lw, i_sw;
  logic i_beq, i_j, i_jal;
  logic k_alu, k_mem, k_jmp;

  assign rtype  = (op == 6'b000000);
  assign i_addu = rtype && (funct == 6'b100001);
  assign i_subu = rtype && (funct == 6'b100011);
  assign i_jr   = rtype && (funct == 6'b001000);
  assign i_jalr = rtype && (funct == 6'b001001);
  assign i_ori  = (op == 6'b001101);
  assign i_lui  = (op == 6'b001111);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);

  assign k_alu = i_addu | i_subu | i_ori | i_lui;
  assign k_mem = i_lw | i_sw;
  assign k_jmp = i_j | i_jal | i_jr | i_jalr;

  // run stays low while reset is held and until the first edge after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nx = S_FETCH;
    pcwr     = 1'b0;
    irwr     = 1'b0;
    gprwr    = 1'b0;
    dmwr     = 1'b0;
    gprsel   = 2'b00;
    isjalr   = 1'b0;
    wdsel    = 2'b00;
    npcop    = 3'b000;
    aluop    = 2'b00;
    extop    = 1'b0;
    bsel     = 1'b0;
    illegal  = 1'b0;
    if (run) begin
      case (state)
        S_FETCH: begin
          irwr     = 1'b1;
          pcwr     = 1'b1;
          state_nx = S_DCD;
        end
        S_DCD: begin
          unique case (1'b1)
            k_alu:   state_nx = S_EXE;
            k_mem:   state_nx = S_MA;
            i_beq:   state_nx = S_BR;
            k_jmp:   state_nx = S_JMP;
`ifdef MC_CTRL_TRAP_EN
            default: state_nx = S_TRAP;
`else
            default: state_nx = S_FETCH;
`endif
          endcase
        end
        S_EXE: begin
          bsel = i_ori | i_lui;
          unique case (1'b1)
            i_subu:  aluop = 2'b01;
            i_ori:   aluop = 2'b10;
            i_lui:   aluop = 2'b11;
            default: aluop = 2'b00;
          endcase
          state_nx = S_WB;
        end
        S_WB: begin
          gprwr  = 1'b1;
          gprsel = rtype ? 2'b01 : 2'b00;
        end
        S_MA: begin
          bsel     = 1'b1;
          extop    = 1'b1;
          state_nx = i_sw ? S_MW : S_MR;
        end
        S_MW: begin
          bsel  = 1'b1;
          extop = 1'b1;
          dmwr  = 1'b1;
        end
        S_MR: begin
          bsel     = 1'b1;
          extop    = 1'b1;
          state_nx = S_MWB;
        end
        S_MWB: begin
          gprwr = 1'b1;
          wdsel = 2'b01;
        end
        S_BR: begin
          aluop = 2'b01;
          pcwr  = zero;
          npcop = 3'b001;
        end
        S_JMP: begin
          pcwr  = 1'b1;
          npcop = (i_jr | i_jalr) ? 3'b011 : 3'b010;
          if (i_jal) begin
            gprwr  = 1'b1;
            gprsel = 2'b10;
            wdsel  = 2'b10;
          end
          if (i_jalr) begin
            gprwr  = 1'b1;
            gprsel = 2'b01;
            isjalr = 1'b1;
            wdsel  = 2'b10;
          end
        end
`ifdef MC_CTRL_TRAP_EN
        S_TRAP: begin
          illegal = 1'b1;
          gprwr   = 1'b1;
          gprsel  = 2'b11;
          wdsel   = 2'b10;
          pcwr    = 1'b1;
          npcop   = 3'b100;
        end
`endif
        default: state_nx = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction output
// schedules built from the instruction table, checked every cycle.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pcwr, irwr, gprwr, dmwr, isjalr, extop, bsel, illegal;
  logic [1:0] gprsel, wdsel, aluop;
  logic [2:0] npcop;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pcwr(pcwr), .irwr(irwr), .gprwr(gprwr), .dmwr(dmwr),
    .gprsel(gprsel), .isjalr(isjalr), .wdsel(wdsel), .npcop(npcop),
    .aluop(aluop), .extop(extop), .bsel(bsel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwr, irwr, gprwr, dmwr;
    logic [1:0] gprsel;
    logic       isjalr;
    logic [1:0] wdsel;
    logic [2:0] npcop;
    logic [1:0] aluop;
    logic       extop, bsel, illegal;
  } ov_t;

  typedef enum {
    ADDU, SUBU, ORI, LUI, LW, SW, BEQ,
    J, JAL, JR, JALR, ILL_OP, ILL_FN
  } ins_t;

  ov_t   got;
  ov_t   exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  string cur = "idle";

  assign got = {pcwr, irwr, gprwr, dmwr, gprsel, isjalr,
                wdsel, npcop, aluop, extop, bsel, illegal};

  task automatic chk(input string tag, input ov_t g, input ov_t e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%05h exp=%05h", tag, g, e);
    end
  endtask

  function automatic logic [11:0] enc(input ins_t k);
    case (k)
      ADDU:    return {6'b000000, 6'b100001};
      SUBU:    return {6'b000000, 6'b100011};
      JR:      return {6'b000000, 6'b001000};
      JALR:    return {6'b000000, 6'b001001};
      ORI:     return {6'b001101, 6'b100011};
      LUI:     return {6'b001111, 6'b100001};
      LW:      return {6'b100011, 6'b001001};
      SW:      return {6'b101011, 6'b000000};
      BEQ:     return {6'b000100, 6'b001000};
      J:       return {6'b000010, 6'b100011};
      JAL:     return {6'b000011, 6'b000000};
      ILL_OP:  return {6'b111111, 6'b100001};
      default: return {6'b000000, 6'b000000};
    endcase
  endfunction

  // Expected output for each cycle of one instruction, FETCH first.
  task automatic plan(input ins_t k, input logic z);
    ov_t v;
    v = '0; v.pcwr = 1'b1; v.irwr = 1'b1;
    exp_q.push_back(v);
    v = '0;
    exp_q.push_back(v);
    case (k)
      ADDU, SUBU, ORI, LUI: begin
        v = '0;
        v.aluop = (k == SUBU) ? 2'b01 : (k == ORI) ? 2'b10 :
                  (k == LUI) ? 2'b11 : 2'b00;
        v.bsel = (k == ORI) || (k == LUI);
        exp_q.push_back(v);
        v = '0; v.gprwr = 1'b1;
        v.gprsel = (k == ADDU || k == SUBU) ? 2'b01 : 2'b00;
        exp_q.push_back(v);
      end
      LW, SW: begin
        v = '0; v.bsel = 1'b1; v.extop = 1'b1;
        exp_q.push_back(v);
        if (k == SW) v.dmwr = 1'b1;
        exp_q.push_back(v);
        if (k == LW) begin
          v = '0; v.gprwr = 1'b1; v.wdsel = 2'b01;
          exp_q.push_back(v);
        end
      end
      BEQ: begin
        v = '0; v.aluop = 2'b01; v.pcwr = z; v.npcop = 3'b001;
        exp_q.push_back(v);
      end
      J, JAL, JR, JALR: begin
        v = '0; v.pcwr = 1'b1;
        v.npcop = (k == JR || k == JALR) ? 3'b011 : 3'b010;
        if (k == JAL) begin
          v.gprwr = 1'b1; v.gprsel = 2'b10; v.wdsel = 2'b10;
        end
        if (k == JALR) begin
          v.gprwr = 1'b1; v.gprsel = 2'b01;
          v.isjalr = 1'b1; v.wdsel = 2'b10;
        end
        exp_q.push_back(v);
      end
      default: begin
`ifdef MC_CTRL_TRAP_EN
        v = '0; v.illegal = 1'b1; v.gprwr = 1'b1;
        v.gprsel = 2'b11; v.wdsel = 2'b10;
        v.pcwr = 1'b1; v.npcop = 3'b100;
        exp_q.push_back(v);
`endif
      end
    endcase
  endtask

  // Starts an instruction on the next edge; keeps only the first
  // `keep` cycles of its schedule (used to cut it short with reset).
  task automatic run(input ins_t k, input logic z,
                     input int len, input int keep);
    logic [11:0] e;
    @(posedge clk); #1;
    e = enc(k);
    op = e[11:6];
    funct = e[5:0];
    zero = z;
    cur = $sformatf("%s_z%0d", k.name(), z);
    plan(k, z);
    total++;
    if (exp_q.size() != len) begin
      bad++;
      $display("FAIL len_%s got=%0d exp=%0d", cur, exp_q.size(), len);
    end
    if (k == JALR)
      chk("jalr_pin", exp_q[2], 17'b1_0_1_0_01_1_10_011_00_0_0_0);
    while (exp_q.size() > keep) void'(exp_q.pop_back());
    repeat (keep - 1) @(posedge clk);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) chk($sformatf("rst_zero@%0d", cyc), got, '0);
    else if (exp_q.size() != 0)
      chk($sformatf("%s@%0d", cur, cyc), got, exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  localparam int ILL_LEN =
`ifdef MC_CTRL_TRAP_EN
    3;
`else
    2;
`endif

  initial begin
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("post_rst_idle", got, '0);
    run(ADDU,   1'b0, 4, 4);
    run(SUBU,   1'b0, 4, 4);
    run(ORI,    1'b0, 4, 4);
    run(LUI,    1'b0, 4, 4);
    run(LW,     1'b0, 5, 5);
    run(SW,     1'b0, 4, 4);
    run(BEQ,    1'b1, 3, 3);
    run(BEQ,    1'b0, 3, 3);
    run(J,      1'b0, 3, 3);
    run(JAL,    1'b0, 3, 3);
    run(JR,     1'b0, 3, 3);
    run(JALR,   1'b0, 3, 3);
    run(ILL_OP, 1'b0, ILL_LEN, ILL_LEN);
    run(ADDU,   1'b1, 4, 4);
    run(ILL_FN, 1'b0, ILL_LEN, ILL_LEN);
    run(LW,     1'b0, 5, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_mr", got, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_release_idle", got, '0);
    run(SW,     1'b0, 4, 4);
    run(JALR,   1'b0, 3, 3);
    @(negedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

- Multicycle main controller for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives every datapath enable and select, including the destination-register select `gprsel` / `isjalr` pair consumed by the write-register mux in front of the GPR file.
- Sits between the instruction register (source of `op` / `funct`) and the datapath muxes, PC, IR, GPR and data memory.

## Interface

Parameters
- `TRAP_VEC`, default 32'h0000_3180: PC value loaded on an illegal instruction (used only under `MC_CTRL_TRAP_EN`).

Ports
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU equality flag.
- `pcwr` out 1: PC write enable.
- `irwr` out 1: IR write enable.
- `gprwr` out 1: GPR write enable.
- `dmwr` out 1: data memory write enable.
- `gprsel` out 2: destination select; 00 = rt, 01 = rd, 10 = $31, 11 = $30.
- `isjalr` out 1: high only for jalr write-back.
- `wdsel` out 2: GPR write data; 00 = ALU, 01 = DM, 10 = PC.
- `npcop` out 3: next PC; 000 = PC+4, 001 = branch, 010 = j target, 011 = register (rs), 100 = `TRAP_VEC`.
- `aluop` out 2: 00 = add, 01 = sub, 10 = or, 11 = lui.
- `extop` out 1: 1 = sign-extend imm16, 0 = zero-extend.
- `bsel` out 1: ALU B operand; 1 = extended immediate, 0 = rt.
- `illegal` out 1: high in TRAP state.

## Operation

Supported instructions:
- R-type (op 000000) by `funct`: addu 100001, subu 100011, jr 001000, jalr 001001.
- ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Anything else is illegal.

States and outputs. Outputs are Moore outputs decoded from the state and from the held `op`/`funct`. Any output not listed is 0; selects default to 0.
- FETCH: `irwr` = 1, `pcwr` = 1, `npcop` = 000. Always goes to DCD.
- DCD:
  - R-arith, ori, lui → EXE.
  - lw, sw → MA.
  - beq → BR.
  - j, jal, jr, jalr → JMP.
  - Illegal → TRAP with the macro, FETCH without it.
- EXE:
  - R-arith: `bsel` = 0; `aluop` = 00 for addu, 01 for subu.
  - ori: `bsel` = 1, `extop` = 0, `aluop` = 10.
  - lui: `bsel` = 1, `aluop` = 11.
  - Next state → WB.
- WB: `gprwr` = 1, `wdsel` = 00. `gprsel` = 01 for R-type, 00 for immediates. Next state → FETCH.
- MA: `bsel` = 1, `extop` = 1, `aluop` = 00. lw → MR; sw → MW.
- MW: `dmwr` = 1, with MA's ALU controls held. Next state → FETCH.
- MR: MA's ALU controls held. Next state → MWB.
- MWB: `gprwr` = 1, `wdsel` = 01, `gprsel` = 00. Next state → FETCH.
- BR: `aluop` = 01, `bsel` = 0, `pcwr` = `zero`, `npcop` = 001. Next state → FETCH.
- JMP: `pcwr` = 1. Next state → FETCH.
  - j: `npcop` = 010.
  - jal: `npcop` = 010, `gprwr` = 1, `gprsel` = 10, `wdsel` = 10.
  - jr: `npcop` = 011.
  - jalr: `npcop` = 011, `gprwr` = 1, `gprsel` = 01, `isjalr` = 1, `wdsel` = 10.
- TRAP: `illegal` = 1, `gprwr` = 1, `gprsel` = 11, `wdsel` = 10, `pcwr` = 1, `npcop` = 100. Next state → FETCH.

Rules:
- `wdsel` = 10 writes the current PC. After FETCH the PC already holds the instruction address + 4, so link values equal instruction address + 4.
- The PC register updates on the same edge that leaves the state.
- Unused state encodings return to FETCH on the next edge with all enables 0.

## Timing

- `rst` high: state = FETCH asynchronously. All outputs are forced to 0, including `pcwr`/`irwr`, and stay 0 until the first rising edge after `rst` falls.
- Cycles per instruction, FETCH through last state:
  - R-arith, ori, lui, sw: 4.
  - lw: 5.
  - beq, j, jal, jr, jalr: 3.
  - Illegal: 3 with the macro, 2 without.
- `rst` asserted mid-instruction: that instruction is abandoned. No further `gprwr`/`dmwr` is issued; execution restarts at FETCH.
- `op`/`funct` are sampled in every state. They must stay stable from the DCD cycle to the end of the instruction; `irwr` is low in those states.

## Configuration

- `MC_CTRL_TRAP_EN` defined:
  - TRAP state is present.
  - Illegal instructions write instruction address + 4 into $30 and jump to `TRAP_VEC`.
  - `illegal` pulses for one cycle.
- Not defined:
  - Illegal instructions execute as a 2-cycle NOP: FETCH → DCD → FETCH, with no writes.
  - `illegal` is tied to 0.

## Test plan

- addu (op 0, funct 100001), reset released → FETCH/DCD/EXE/WB. WB cycle shows `gprwr` = 1, `gprsel` = 01, `wdsel` = 00. `pcwr` high only in the FETCH cycle.
- lw at PC 0x3000 → 5 cycles. MWB shows `gprwr` = 1, `gprsel` = 00, `wdsel` = 01. sw → 4 cycles with `dmwr` = 1 only in MW.
- beq: `zero` = 1 → BR shows `pcwr` = 1, `npcop` = 001. `zero` = 0 → `pcwr` = 0. Both take 3 cycles.
- jal → JMP shows `gprsel` = 10, `wdsel` = 10, `npcop` = 010. jalr (funct 001001) → `gprsel` = 01, `isjalr` = 1, `npcop` = 011. `isjalr` = 0 in every other state and instruction.
- op 111111:
  - With `MC_CTRL_TRAP_EN` → TRAP cycle shows `illegal` = 1, `gprsel` = 11, `gprwr` = 1, `npcop` = 100.
  - Without it → FETCH again 2 cycles after the first FETCH; no `gprwr`.
- `rst` pulsed asynchronously (between clock edges) during the MR state of a lw → all outputs 0 immediately, no MWB write. First post-reset edge runs FETCH.
